// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
// The memory answers combinationally: imem_rdata is the word at imem_addr in the same cycle.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID pipeline register.
// Redirects squash the instruction fetched in the same cycle, because there are no delay slots.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump,
  input  logic          Jr_Jalr,
  input  logic [31:0]   jr_target,
  fetch_stage_if.master imem,
  output logic [31:0]   pc,
  output logic [31:0]   if_id_instr,
  output logic [31:0]   if_id_pc_plus4,
  output logic          if_id_valid
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        redirect;

  assign pc_plus4 = pc + 32'd4;

  // A stalled ID stage re-asserts its redirect once the stall clears, so it is ignored while stalled.
  assign redirect = !stall && (branch_taken || jump);

  assign jump_target = Jr_Jalr ? (jr_target & WORD_MASK)
                               : {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00};

  // Jump wins over a simultaneous taken branch.
  assign redirect_target = jump ? jump_target : (branch_target & WORD_MASK);

  assign imem.imem_addr = pc;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC & WORD_MASK;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else if (stall) begin
      // PC holds; an accompanying flush still squashes the held IF/ID entry.
      if (flush) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end
    end else begin
      pc <= redirect ? redirect_target : pc_plus4;
      if (redirect || flush) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else begin
        if_id_instr    <= imem.imem_rdata;
        if_id_pc_plus4 <= pc_plus4;
        if_id_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipelined MIPS core: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register whose `opcode`/`funct` fields feed the Controller in ID. It computes the next PC from sequential, branch, jump (`j`/`jal`) and register-jump (`jr`/`jalr`) sources. It also applies stall and squash requests from the hazard logic. There are no branch delay slots: every redirect squashes the instruction fetched in the same cycle.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0000, bubble encoding (`sll $0,$0,0`) written to IF/ID on squash/reset

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  load-use hold from hazard unit: PC and IF/ID keep their values
- `flush`  in  1  external squash: IF/ID loaded with bubble
- `branch_taken`  in  1  beq/bne in ID resolved taken
- `branch_target`  in  32  branch target computed in ID
- `jump`  in  1  Controller `jump` for the ID instruction
- `Jr_Jalr`  in  1  Controller `Jr_Jalr`: target comes from register
- `jr_target`  in  32  forwarded rs value for jr/jalr
- `imem_addr`  out  32  instruction memory address (= `pc`)
- `imem_rdata`  in  32  instruction word, combinational read of `imem_addr`
- `pc`  out  32  current fetch PC
- `if_id_instr`  out  32  IF/ID instruction (to Controller opcode=[31:26], funct=[5:0])
- `if_id_pc_plus4`  out  32  IF/ID PC+4 (branch base, jal/jalr link value)
- `if_id_valid`  out  1  1 = real instruction, 0 = bubble

## Operation
- `redirect = !stall && (branch_taken || jump)`.
- Jump target: `Jr_Jalr` ? `{jr_target[31:2],2'b00}` : `{if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}`.
- Next-PC source when redirect: if `jump`, the jump target. Jump beats `branch_taken` if both are set. Otherwise `{branch_target[31:2],2'b00}`.
- Per rising edge, first matching row wins:
  1. `rst`: `pc`=RESET_PC, `if_id_instr`=NOP_INSTR, `if_id_pc_plus4`=0, `if_id_valid`=0.
  2. `stall && !flush`: everything holds. Any redirect this cycle is ignored, because ID is held and re-asserts it next cycle.
  3. `stall && flush`: `pc` holds; IF/ID takes the bubble (NOP_INSTR, valid=0, pc_plus4 holds).
  4. `redirect` (with or without `flush`): `pc` = target; IF/ID takes the bubble.
  5. `flush`: `pc` = pc+4; IF/ID takes the bubble.
  6. Normal: `pc` = pc+4; `if_id_instr`=`imem_rdata`, `if_id_pc_plus4`=pc+4, `if_id_valid`=1.
- Arithmetic: pc+4 is a 32-bit add, modulo 2^32 (32'hFFFF_FFFC+4 → 0). `pc[1:0]` is always 00.
- Outputs are registered except `imem_addr`, which is a wire equal to `pc`.

## Timing
- Fetch latency: the instruction at PC p appears on `if_id_instr` on the edge after `pc`==p. That is one cycle, and the Controller decodes it in the same cycle.
- Redirect: target appears on `pc` 1 cycle after `branch_taken`/`jump` is sampled. Penalty is exactly 1 bubble.
- Stall holds for N cycles with N≥1. Normal fetch resumes on the first edge with `stall`=0 and no extra bubble.
- Reset mid-stream: it overrides stall, flush and redirect on the same edge. First real instruction (from RESET_PC) is valid in IF/ID 1 cycle after `rst` deasserts.
- Inputs `stall`, `flush`, `branch_taken`, `jump`, `Jr_Jalr` and the targets only need to be stable at the rising edge. No handshake beyond that.

## Test plan
- Reset then sequential run: imem[0..2]=A,B,C. After rst deasserts, `pc` goes 0,4,8,12. `if_id_instr` goes NOP,A,B,C and `if_id_valid` goes 0,1,1,1.
- Taken beq: branch_taken=1, branch_target=0x40 while ID holds the branch at pc 8. Required: next `pc`=0x40; the instruction at 12 is squashed (IF/ID=NOP, valid=0); the word at 0x40 is in IF/ID one cycle later.
- `j` with if_id_pc_plus4=0x9000_0010, index=26'h000_0100 → `pc`=0x9000_0400. `jr` with jr_target=0x0000_1237 → `pc`=0x0000_1234, and 1 bubble in each case.
- Stall 3 cycles with branch_taken=1 during the stall: `pc` and IF/ID stay frozen and there is no redirect. On the first unstalled edge the redirect happens to branch_target.
- Wrap and simultaneity: from pc=0xFFFF_FFFC the next `pc` is 0. When jump=1 and branch_taken=1 together, the jump target wins. When stall=1 and flush=1 together, `pc` holds, IF/ID=NOP and valid=0.
- rst pulsed while stall=1 and jump=1: `pc`=RESET_PC, IF/ID=NOP and valid=0 on that edge.
